fc_accum_requant: RTL
=====================

// Module: fc_accum_requant
// PURPOSE
// Sits directly downstream of the 6-row FC systolic column and consumes its 32-bit output_mac stream.
// Each neuron's dot product arrives as NUM_CHUNKS 6-wide partial sums; this block sums them and adds a per-neuron bias.
// It then applies arithmetic shift with rounding, optional ReLU and saturation to int8, and buffers results in an output FIFO.
// Issue credit keeps the feeder from overrunning that FIFO.
// PARAMETERS
// ACC_W          32  accumulator / mac_in / bias width (signed)
// OUT_W          8   output width (signed)
// ARRAY_LATENCY  6   cycles from issue (chunk driven into array) to its valid sum on mac_in
// CNT_W          10  width of chunk and neuron counters
// FIFO_DEPTH     4   output FIFO entries (power of 2)
// PORTS
// clk          in   1       clock, all logic on posedge
// rst          in   1       synchronous, active-high reset
// start        in   1       1-cycle pulse; latches num_chunks, num_neurons, shift, relu_en; honoured only in IDLE
// num_chunks   in   CNT_W   chunks per neuron; 0 treated as 1
// num_neurons  in   CNT_W   neurons in the layer
// shift        in   5       right-shift amount for requant
// relu_en      in   1       1: clamp negatives to 0 before saturation
// issue        in   1       feeder drives one chunk into the array this cycle
// bias         in   ACC_W   signed bias; sampled on issue of a neuron's first chunk
// issue_ready  out  1       feeder may assert issue
// mac_in       in   ACC_W   signed partial sum (array output_mac)
// out_valid    out  1       out_data holds a result (FIFO head)
// out_ready    in   1       consumer accepts head when out_valid && out_ready
// out_data     out  OUT_W   signed int8 neuron result
// busy         out  1       state != IDLE
// done         out  1       1-cycle pulse: all num_neurons results popped
// err          out  1       sticky: issue while !issue_ready; cleared only by rst
// BEHAVIOUR
// Reset: state IDLE; all counters, delay line, FIFOs and accumulator cleared.
// Reset values: issue_ready=0, out_valid=0, out_data=0, busy=0, done=0, err=0. Reset mid-layer discards all in-flight data.
// FSM: IDLE -start-> RUN.
//   RUN: issue_ready = (fifo_count + pending) < FIFO_DEPTH && neurons_issued < num_neurons.
//   RUN -> DRAIN when the last chunk of the last neuron is issued.
//   DRAIN -> DONE when neurons_popped == num_neurons. DONE: done=1 for one cycle -> IDLE.
//   num_neurons=0: start -> DONE next cycle.
// Issue side: accepted issue = issue && issue_ready. chunk_cnt increments and wraps at num_chunks.
//   First chunk of a neuron: pending++ and bias pushed into bias queue (depth FIFO_DEPTH).
//   issue while !issue_ready (including IDLE/DRAIN): ignored, err<=1.
// Delay line: ARRAY_LATENCY-deep shift register of accepted issue bits -> mac_valid aligned with mac_in.
// Accumulate: on mac_valid, first chunk: acc <= bias_q_head + mac_in (bias popped); else acc <= acc + mac_in.
//   Arithmetic is two's-complement ACC_W, wraps (no saturation).
// Requant stage (1 register after last chunk's acc update):
//   r = (acc + (shift ? 1<<(shift-1) : 0)) >>> shift, computed in ACC_W+1 bits.
//   If relu_en and r<0 then r=0. Saturate to [-128,127].
// FIFO push on requant result; pending-- same cycle. Pop on out_valid && out_ready; push+pop same cycle legal, count unchanged.
// Latency: last mac_valid at cycle T -> out_valid at T+2 when FIFO was empty.
// Credit guarantees no push into a full FIFO; a push while full is a design bug (assert).
// out_data holds steady while out_valid && !out_ready.
// TESTING
// 1 chunk, bias=10, mac_in=118, shift=0, relu=0 -> out_data=127 (saturated), done after pop.
// 3 chunks, bias=-5, mac_in=100,200,-40, shift=2 -> acc=255, (255+2)>>>2=64 -> out_data=64.
// relu_en=1, bias=0, mac_in=-300, shift=1 -> 0; same with relu_en=0 -> -128.
// out_ready=0, 8 neurons of 1 chunk -> issue_ready drops after 4 issues, no loss; release -> 8 results in order.
// issue while IDLE -> err=1, no result produced; rst -> err=0.
// rst asserted mid-RUN with 2 results queued -> next cycle out_valid=0, busy=0; new start runs cleanly.

Source files
------------

// File: rtl/fc_accum_requant.sv
// Accumulates chunked partial sums from the FC systolic column, adds per-neuron bias, requantises
// to int8 (round, shift, optional ReLU, saturate) and buffers results in a credit-protected FIFO.
module fc_accum_requant #(
  parameter int unsigned ACC_W         = 32,
  parameter int unsigned OUT_W         = 8,
  parameter int unsigned ARRAY_LATENCY = 6,
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_chunks,
  input  logic [CNT_W-1:0]        num_neurons,
  input  logic [4:0]              shift,
  input  logic                    relu_en,
  input  logic                    issue,
  input  logic signed [ACC_W-1:0] bias,
  output logic                    issue_ready,
  input  logic signed [ACC_W-1:0] mac_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned CrW  = CntW + 1;
  localparam int unsigned RW   = ACC_W + 1;
  localparam logic signed [RW-1:0] SatMax = RW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
  state_e state_q, state_d;

  logic [CNT_W-1:0]        nchunks_q, nneurons_q;
  logic [4:0]              shift_q;
  logic                    relu_q;
  logic [CNT_W-1:0]        chunk_cnt_q, mac_cnt_q, issued_q, popped_q;
  logic [CntW-1:0]         pending_q;
  logic [ARRAY_LATENCY-1:0] dly_q;
  logic signed [ACC_W-1:0] bq_mem [FIFO_DEPTH];
  logic [PtrW-1:0]         bq_wr_q, bq_rd_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    acc_last_q;
  logic signed [OUT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]         wr_q, rd_q;
  logic [CntW-1:0]         fifo_cnt_q;
  logic                    err_q;

  logic                    iss_acc, iss_first, iss_last;
  logic                    mac_valid, mac_first, mac_last;
  logic                    push, pop;
  logic [CrW-1:0]          credit;
  logic signed [RW-1:0]    rnd, sum, r;
  logic signed [OUT_W-1:0] q8;

  // Pending neurons reserve FIFO slots so an accepted first chunk always has room to land.
  assign credit      = {1'b0, fifo_cnt_q} + {1'b0, pending_q};
  assign issue_ready = (state_q == StRun) && (credit < CrW'(FIFO_DEPTH)) &&
                       (issued_q < nneurons_q);
  assign iss_acc     = issue && issue_ready;
  assign iss_first   = (chunk_cnt_q == '0);
  assign iss_last    = (chunk_cnt_q == nchunks_q - CNT_W'(1));

  assign mac_valid   = dly_q[ARRAY_LATENCY-1];
  assign mac_first   = (mac_cnt_q == '0);
  assign mac_last    = (mac_cnt_q == nchunks_q - CNT_W'(1));

  assign push        = acc_last_q;
  assign out_valid   = (fifo_cnt_q != '0);
  assign pop         = out_valid && out_ready;
  assign out_data    = out_valid ? fifo_mem[rd_q] : '0;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign err         = err_q;

  always_comb begin
    rnd = '0;
    if (shift_q != '0) rnd = RW'(1) << (shift_q - 5'd1);
    sum = $signed({acc_q[ACC_W-1], acc_q}) + rnd;
    r   = sum >>> shift_q;
    if (relu_q && r[RW-1]) r = '0;
    if (r > SatMax)      q8 = SatMax[OUT_W-1:0];
    else if (r < SatMin) q8 = SatMin[OUT_W-1:0];
    else                 q8 = r[OUT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (num_neurons == '0) ? StDone : StRun;
      StRun:   if (iss_acc && iss_last && (issued_q == nneurons_q - CNT_W'(1))) state_d = StDrain;
      StDrain: if (popped_q == nneurons_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      nchunks_q   <= CNT_W'(1);
      nneurons_q  <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      chunk_cnt_q <= '0;
      mac_cnt_q   <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      pending_q   <= '0;
      dly_q       <= '0;
      bq_wr_q     <= '0;
      bq_rd_q     <= '0;
      acc_q       <= '0;
      acc_last_q  <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      fifo_cnt_q  <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        bq_mem[i]   <= '0;
        fifo_mem[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (issue && !issue_ready) err_q <= 1'b1;

      if (state_q == StIdle && start) begin
        nchunks_q   <= (num_chunks == '0) ? CNT_W'(1) : num_chunks;
        nneurons_q  <= num_neurons;
        shift_q     <= shift;
        relu_q      <= relu_en;
        chunk_cnt_q <= '0;
        mac_cnt_q   <= '0;
        issued_q    <= '0;
        popped_q    <= '0;
      end

      if (iss_acc) begin
        chunk_cnt_q <= iss_last ? '0 : chunk_cnt_q + CNT_W'(1);
        if (iss_last) issued_q <= issued_q + CNT_W'(1);
        if (iss_first) begin
          bq_mem[bq_wr_q] <= bias;
          bq_wr_q         <= bq_wr_q + PtrW'(1);
        end
      end
      pending_q <= pending_q + CntW'(iss_acc && iss_first) - CntW'(push);

      dly_q      <= {dly_q[ARRAY_LATENCY-2:0], iss_acc};
      acc_last_q <= mac_valid && mac_last;
      if (mac_valid) begin
        mac_cnt_q <= mac_last ? '0 : mac_cnt_q + CNT_W'(1);
        if (mac_first) begin
          acc_q   <= bq_mem[bq_rd_q] + mac_in;
          bq_rd_q <= bq_rd_q + PtrW'(1);
        end else begin
          acc_q <= acc_q + mac_in;
        end
      end

      if (push) begin
        fifo_mem[wr_q] <= q8;
        wr_q           <= wr_q + PtrW'(1);
      end
      if (pop) begin
        rd_q     <= rd_q + PtrW'(1);
        popped_q <= popped_q + CNT_W'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  // Credit makes overflow unreachable; firing here means the credit accounting is broken.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && (fifo_cnt_q == CntW'(FIFO_DEPTH))));
  end

endmodule
